andchain_trace_capture: RTL and testbench

//  Downstream stage of the AndChain top: samples the d/e/f outputs of all spec lanes each clk,

---
 rtl/andchain_trace_pkg.sv | 17 +
 rtl/andchain_trace_fifo.sv | 50 +++++
 rtl/andchain_trace_capture.sv | 127 ++++++++++++
 tb/tb_andchain_trace_capture.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/andchain_trace_pkg.sv
// Shared types and sizing helpers for the AndChain trace capture stage.
package andchain_trace_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2
   } state_e;

   localparam int DROP_W = 16;

   // Width of one change record: timestamp followed by the f/e/d lane words.
   function automatic int rec_w(input int n, input int ts_w);
      return ts_w + 3 * n;
   endfunction

endpackage

// File: rtl/andchain_trace_fifo.sv
// Synchronous show-ahead FIFO for trace records. Pointers carry one extra
// wrap bit so full and empty are distinguished without a separate counter.
module andchain_trace_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_push;
   logic         do_pop;

   // Status flags and accept decisions; a pop frees the slot a same-cycle push needs.
   always_comb begin
      empty   = (wr_ptr == rd_ptr);
      full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];
   end

   // Pointer update; reset discards whatever is stored.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage array, written only on an accepted push.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/andchain_trace_capture.sv
// Samples the d/e/f lane outputs every cycle, detects changes and queues
// timestamped change records for the trace writer.
//
// state | meaning
// IDLE  | capture off, timestamp held at 0, FIFO still drains
// ARM   | single cycle; sample taken here is recorded unconditionally
// RUN   | sample recorded only when it differs from the previous one
module andchain_trace_capture
   import andchain_trace_pkg::*;
#(
   parameter int NUM_LANES = 5,
   parameter int TS_W      = 16,
   parameter int DEPTH     = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic [NUM_LANES-1:0]        d_in,
   input  logic [NUM_LANES-1:0]        e_in,
   input  logic [NUM_LANES-1:0]        f_in,
   output logic                        rec_valid,
   input  logic                        rec_ready,
   output logic [TS_W+3*NUM_LANES-1:0] rec_data,
   input  logic                        clear_ovf,
   output logic                        overflow,
   output logic [DROP_W-1:0]           drop_count
);

   localparam int SAMP_W = 3 * NUM_LANES;
   localparam int REC_W  = rec_w(NUM_LANES, TS_W);

   state_e            state_q;
   state_e            state_d;
   logic [TS_W-1:0]   ts_q;
   logic [TS_W-1:0]   ts_d;

   logic [SAMP_W-1:0] cur_q;
   logic [SAMP_W-1:0] prev_q;
   logic [TS_W-1:0]   cur_ts_q;
   logic              cur_force_q;
   logic              cur_cmp_q;

   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic              drop;
   logic [REC_W-1:0]  push_rec;

   // Next state and timestamp; ts stays 0 whenever IDLE is current or next.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (enable) state_d = ARM;
         ARM:     state_d = enable ? RUN : IDLE;
         RUN:     if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_q == IDLE || state_d == IDLE) ts_d = '0;
      else                                    ts_d = ts_q + TS_W'(1);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Sampling stage: each sample carries the ts and capture mode of the cycle it was taken in,
   // so a record pushed after enable drops still reports its own cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ts_q        <= '0;
         cur_q       <= '0;
         prev_q      <= '0;
         cur_ts_q    <= '0;
         cur_force_q <= 1'b0;
         cur_cmp_q   <= 1'b0;
      end else begin
         ts_q        <= ts_d;
         cur_q       <= {f_in, e_in, d_in};
         prev_q      <= cur_q;
         cur_ts_q    <= ts_q;
         cur_force_q <= (state_q == ARM);
         cur_cmp_q   <= (state_q == RUN);
      end
   end

   // Record generation and drop detection.
   always_comb begin
      push      = cur_force_q || (cur_cmp_q && (cur_q != prev_q));
      push_rec  = {cur_ts_q, cur_q};
      rec_valid = !empty;
      pop       = rec_valid && rec_ready;
      drop      = push && full && !pop;
   end

   andchain_trace_fifo #(
      .W     (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (push_rec),
      .pop   (pop),
      .dout  (rec_data),
      .full  (full),
      .empty (empty)
   );

   // Sticky overflow and saturating drop counter; a drop outranks a same-cycle clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clear_ovf)               drop_count <= DROP_W'(1);
         else if (drop_count != '1)   drop_count <= drop_count + DROP_W'(1);
      end else if (clear_ovf) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end
   end

endmodule

// File: tb/tb_andchain_trace_capture.sv
// Scoreboard bench for andchain_trace_capture: each scenario task queues the
// records it expects; a monitor compares every accepted record in order.
module tb_andchain_trace_capture;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [4:0]  d_in;
   logic [4:0]  e_in;
   logic [4:0]  f_in;
   logic        rec_ready;
   logic        clear_ovf;

   logic        rec_valid;
   logic [30:0] rec_data;
   logic        overflow;
   logic [15:0] drop_count;

   logic        rec_valid4;
   logic [18:0] rec_data4;
   logic        overflow4;
   logic [15:0] drop_count4;

   logic [30:0] exp_q[$];
   logic [18:0] exp_q4[$];
   int          n_checks;
   int          n_fail;
   int          n_pop;
   bit          chk4;

   andchain_trace_capture #(.NUM_LANES(5), .TS_W(16), .DEPTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .d_in(d_in), .e_in(e_in), .f_in(f_in),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
      .clear_ovf(clear_ovf), .overflow(overflow), .drop_count(drop_count)
   );

   andchain_trace_capture #(.NUM_LANES(5), .TS_W(4), .DEPTH(16)) dut4 (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .d_in(d_in), .e_in(e_in), .f_in(f_in),
      .rec_valid(rec_valid4), .rec_ready(rec_ready), .rec_data(rec_data4),
      .clear_ovf(clear_ovf), .overflow(overflow4), .drop_count(drop_count4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [30:0] mk_rec(input int ts, input logic [4:0] f,
                                          input logic [4:0] e, input logic [4:0] d);
      logic [15:0] t;
      t = ts[15:0];
      return {t, f, e, d};
   endfunction

   function automatic logic [18:0] mk_rec4(input int ts, input logic [4:0] f,
                                           input logic [4:0] e, input logic [4:0] d);
      logic [3:0] t;
      t = ts[3:0];
      return {t, f, e, d};
   endfunction

   // Main DUT: every handshake must match the oldest expected record.
   always @(negedge clk) begin
      if (rst_n && rec_valid && rec_ready) begin
         n_checks++;
         n_pop++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rec_unexpected: got %h, no record expected", rec_data);
         end else begin
            if (rec_data !== exp_q[0]) begin
               n_fail++;
               $display("FAIL rec_data: got %h required %h", rec_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
      end
   end

   // Narrow-timestamp DUT, checked only during the wrap scenario.
   always @(negedge clk) begin
      if (chk4 && rst_n && rec_valid4 && rec_ready) begin
         n_checks++;
         if (exp_q4.size() == 0) begin
            n_fail++;
            $display("FAIL rec4_unexpected: got %h, no record expected", rec_data4);
         end else begin
            if (rec_data4 !== exp_q4[0]) begin
               n_fail++;
               $display("FAIL rec4_data: got %h required %h", rec_data4, exp_q4[0]);
            end
            void'(exp_q4.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_ovf = 1'b0;
      for (int i = 0; i < 2; i++) begin
         enable = 1'($urandom);
         d_in = 5'($urandom);
         e_in = 5'($urandom);
         f_in = 5'($urandom);
         rec_ready = 1'($urandom);
         step();
      end
      n_checks++;
      if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", rec_valid); end
      n_checks++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b required 0", overflow); end
      n_checks++;
      if (drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drop_count: got %0d required 0", drop_count); end
      n_checks++;
      if (rec_data !== 31'd0) begin n_fail++; $display("FAIL reset_rec_data: got %h required 0", rec_data); end
      enable = 1'b0;
      d_in = 5'd0;
      e_in = 5'd0;
      f_in = 5'd0;
      rec_ready = 1'b1;
      rst_n = 1'b1;
      repeat (3) step();
      n_checks++;
      if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b required 0", rec_valid); end
   endtask

   task automatic test_baseline();
      d_in = 5'h01;
      e_in = 5'h00;
      f_in = 5'h00;
      rec_ready = 1'b1;
      n_pop = 0;
      exp_q.push_back(mk_rec(0, 5'h00, 5'h00, 5'h01));
      enable = 1'b1;
      step();
      n_checks++;
      if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL base_arm_valid: got %b required 0", rec_valid); end
      step();
      n_checks++;
      if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL base_latency1: got %b required 0", rec_valid); end
      step();
      n_checks++;
      if (rec_valid !== 1'b1) begin n_fail++; $display("FAIL base_latency2: got %b required 1", rec_valid); end
      step();
      n_checks++;
      if (n_pop != 1 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL base_count: got %0d records, %0d pending, required 1 and 0", n_pop, exp_q.size());
      end
   endtask

   task automatic test_change();
      // Current cycle carries ts=3.
      e_in = 5'h04;
      exp_q.push_back(mk_rec(3, 5'h00, 5'h04, 5'h01));
      repeat (6) step();
      n_checks++;
      if (n_pop != 2 || exp_q.size() != 0 || rec_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL change_count: got %0d records, %0d pending, valid %b, required 2, 0, 0",
                  n_pop, exp_q.size(), rec_valid);
      end
   endtask

   task automatic test_disable_on_change();
      // Current cycle carries ts=9; the change sampled here must still be recorded.
      e_in = 5'h00;
      enable = 1'b0;
      exp_q.push_back(mk_rec(9, 5'h00, 5'h00, 5'h01));
      repeat (6) step();
      n_checks++;
      if (n_pop != 3 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL disable_count: got %0d records, %0d pending, required 3 and 0", n_pop, exp_q.size());
      end
      d_in = 5'h1f;
      repeat (4) step();
      n_checks++;
      if (rec_valid !== 1'b0 || n_pop != 3) begin
         n_fail++;
         $display("FAIL idle_capture: got valid %b records %0d, required 0 and 3", rec_valid, n_pop);
      end
   endtask

   task automatic test_overflow();
      rec_ready = 1'b0;
      d_in = 5'd0;
      enable = 1'b1;
      step();
      for (int i = 0; i <= 20; i++) begin
         d_in = 5'(i);
         if (i < 16) exp_q.push_back(mk_rec(i, 5'h00, 5'h00, 5'(i)));
         step();
      end
      enable = 1'b0;
      repeat (2) step();
      n_checks++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b required 1", overflow); end
      n_checks++;
      if (drop_count !== 16'd5) begin n_fail++; $display("FAIL ovf_drop_count: got %0d required 5", drop_count); end
      repeat (3) step();
      n_checks++;
      if (rec_valid !== 1'b1 || rec_data !== mk_rec(0, 5'h00, 5'h00, 5'h00)) begin
         n_fail++;
         $display("FAIL ovf_head_hold: got valid %b data %h required 1 %h",
                  rec_valid, rec_data, mk_rec(0, 5'h00, 5'h00, 5'h00));
      end
      clear_ovf = 1'b1;
      step();
      clear_ovf = 1'b0;
      n_checks++;
      if (overflow !== 1'b0 || drop_count !== 16'd0) begin
         n_fail++;
         $display("FAIL ovf_clear: got %b/%0d required 0/0", overflow, drop_count);
      end
   endtask

   task automatic test_full_push_pop();
      bit drained;
      // Baseline record arrives at a full FIFO on the same edge as a pop.
      enable = 1'b1;
      step();
      enable = 1'b0;
      step();
      exp_q.push_back(mk_rec(0, 5'h00, 5'h00, 5'd20));
      rec_ready = 1'b1;
      step();
      rec_ready = 1'b0;
      n_checks++;
      if (overflow !== 1'b0 || drop_count !== 16'd0) begin
         n_fail++;
         $display("FAIL full_push_pop: got %b/%0d required 0/0", overflow, drop_count);
      end
      // Drop on the same edge as a clear: the drop wins.
      enable = 1'b1;
      step();
      enable = 1'b0;
      step();
      clear_ovf = 1'b1;
      step();
      clear_ovf = 1'b0;
      n_checks++;
      if (overflow !== 1'b1 || drop_count !== 16'd1) begin
         n_fail++;
         $display("FAIL clear_vs_drop: got %b/%0d required 1/1", overflow, drop_count);
      end
      clear_ovf = 1'b1;
      step();
      clear_ovf = 1'b0;
      n_pop = 0;
      rec_ready = 1'b1;
      drained = 1'b0;
      for (int i = 0; i < 40 && !drained; i++) begin
         step();
         if (rec_valid === 1'b0) drained = 1'b1;
      end
      n_checks++;
      if (!drained || n_pop != 16 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL full_drain: got drained %b records %0d pending %0d, required 1, 16, 0",
                  drained, n_pop, exp_q.size());
      end
      repeat (3) step();
      n_checks++;
      if (rec_valid !== 1'b0 || n_pop != 16) begin
         n_fail++;
         $display("FAIL empty_pop: got valid %b records %0d, required 0 and 16", rec_valid, n_pop);
      end
   endtask

   task automatic test_wrap_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk4 = 1'b1;
      rec_ready = 1'b1;
      d_in = 5'd0;
      enable = 1'b1;
      step();
      for (int i = 0; i < 20; i++) begin
         d_in = 5'(i);
         exp_q.push_back(mk_rec(i, 5'h00, 5'h00, 5'(i)));
         exp_q4.push_back(mk_rec4(i, 5'h00, 5'h00, 5'(i)));
         step();
      end
      repeat (4) step();
      n_checks++;
      if (exp_q.size() != 0 || exp_q4.size() != 0) begin
         n_fail++;
         $display("FAIL wrap_pending: got %0d and %0d pending, required 0 and 0", exp_q.size(), exp_q4.size());
      end
      rec_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         d_in = 5'(i + 1);
         step();
      end
      n_checks++;
      if (rec_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_prefill: got %b required 1", rec_valid); end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      enable = 1'b0;
      n_checks++;
      if (rec_valid !== 1'b0 || rec_valid4 !== 1'b0 || rec_data !== 31'd0) begin
         n_fail++;
         $display("FAIL midrst_flush: got valid %b/%b data %h required 0/0 0", rec_valid, rec_valid4, rec_data);
      end
      rec_ready = 1'b1;
      repeat (4) step();
      n_checks++;
      if (rec_valid !== 1'b0 || rec_valid4 !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_after: got valid %b/%b required 0/0", rec_valid, rec_valid4);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      n_pop = 0;
      chk4 = 1'b0;
      rst_n = 1'b0;
      enable = 1'b0;
      d_in = 5'd0;
      e_in = 5'd0;
      f_in = 5'd0;
      rec_ready = 1'b0;
      clear_ovf = 1'b0;
      test_reset();
      test_baseline();
      test_change();
      test_disable_on_change();
      test_overflow();
      test_full_push_pop();
      test_wrap_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
